// File: rtl/load_store_unit.sv
// Data-memory access stage: validates the op, runs one ready/request bus
// transaction, then aligns/extends load data for writeback.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        load_we
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [7:0] TMO      = 8'(TIMEOUT);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [31:0] word_r;
  logic [2:0]  f3_r;
  logic [1:0]  lo_r;
  logic        load_r;
  logic        err_r;

  logic        op_err;
  logic [3:0]  strb_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;

  always_comb begin
    op_err = (op_load == op_store)
          || !(op_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
          || (op_store && op_funct3[2])
          || (op_funct3[1:0] == 2'b01 && op_addr[0])
          || (op_funct3[1:0] == 2'b10 && op_addr[1:0] != 2'b00);
    strb_n  = '0;
    wdata_n = op_wdata;
    if (op_store) begin
      case (op_funct3[1:0])
        2'b00: begin
          strb_n  = 4'b0001 << op_addr[1:0];
          wdata_n = {4{op_wdata[7:0]}};
        end
        2'b01: begin
          strb_n  = op_addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{op_wdata[15:0]}};
        end
        default: strb_n = 4'b1111;
      endcase
    end
  end

  always_comb begin
    case (lo_r)
      2'd0:    byte_sel = word_r[7:0];
      2'd1:    byte_sel = word_r[15:8];
      2'd2:    byte_sel = word_r[23:16];
      default: byte_sel = word_r[31:24];
    endcase
    half_sel = lo_r[1] ? word_r[31:16] : word_r[15:0];
    case (f3_r)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext = {24'd0, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext = {16'd0, half_sel};
      default: ext = word_r;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      word_r    <= '0;
      f3_r      <= '0;
      lo_r      <= '0;
      load_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            f3_r   <= op_funct3;
            lo_r   <= op_addr[1:0];
            load_r <= op_load;
            if (op_err) begin
              err_r <= 1'b1;
              state <= S_RESP;
            end else begin
              mem_addr  <= {op_addr[31:2], 2'b00};
              mem_we    <= op_store;
              mem_wstrb <= strb_n;
              mem_wdata <= wdata_n;
              cnt       <= '0;
              state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            word_r <= mem_rdata;
            state  <= S_RESP;
          end else if (cnt == TMO) begin
            err_r <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_RESP: begin
          err_r <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request and completion are pure state decodes so reset drops them at once.
  assign mem_req   = (state == S_ACCESS);
  assign done      = (state == S_RESP);
  assign err       = done & err_r;
  assign load_we   = done & load_r & ~err_r;
  assign load_data = load_we ? ext : '0;
  assign stall     = op_valid & ~done;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized ops checked
// against an arithmetic reference of the access rules.
module tb_load_store_unit;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_load, op_store;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall, done, err;
  logic [31:0] load_data;
  logic        load_we;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
    .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .done(done), .err(err),
    .load_data(load_data), .load_we(load_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input bit ld, input bit st, input int f3, input int unsigned a);
    int unsigned sz;
    if (ld == st) return 1;
    if (!(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1;
    if (st && f3 >= 4) return 1;
    sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_strb(input int f3, input int unsigned a);
    if (f3 == 0) return 32'd1 << (a % 4);
    if (f3 == 1) return 32'd3 << (a % 4);
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] wd);
    if (f3 == 0) return (wd % 256) * 32'h01010101;
    if (f3 == 1) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input int unsigned a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * (a % 4));
    case (f3)
      0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      4: v = v % 256;
      1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      5: v = v % 65536;
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int unsigned dly, input logic [31:0] rd);
    bit e_err, e_to, got_done;
    int unsigned e_lat, e_req, cyc, nreq;
    logic [31:0] e_ld;
    e_err = ref_err(ld, st, int'(f3), a);
    e_to  = !e_err && dly > TMO;
    e_lat = e_err ? 1 : (e_to ? TMO + 2 : dly + 2);
    e_req = e_err ? 0 : (e_to ? TMO + 1 : dly + 1);
    e_ld  = (!e_err && !e_to && ld) ? ref_load(int'(f3), a, rd) : 32'd0;
    @(negedge clk);
    op_valid = 1'b1; op_load = ld; op_store = st; op_funct3 = f3;
    op_addr = a; op_wdata = wd; mem_ready = 1'b0; mem_rdata = $urandom;
    #1 chk("stall_accept", 32'(stall), 32'd1);
    cyc = 0; nreq = 0; got_done = 0;
    while (!got_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        nreq++;
        if (nreq == 1) begin
          chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
          chk("mem_we", 32'(mem_we), 32'(st));
          chk("mem_wstrb", 32'(mem_wstrb), st ? ref_strb(int'(f3), a) : 32'd0);
          if (st) chk("mem_wdata", mem_wdata, ref_wdata(int'(f3), wd));
        end
        if (nreq == dly + 1) begin
          mem_ready = 1'b1; mem_rdata = rd;
        end else begin
          mem_ready = 1'b0; mem_rdata = $urandom;
        end
      end else begin
        mem_ready = 1'b0;
      end
      chk("stall", 32'(stall), 32'(!done));
      if (done) begin
        got_done = 1;
        chk("latency", cyc, e_lat);
        chk("req_cycles", nreq, e_req);
        chk("err", 32'(err), 32'(e_err || e_to));
        chk("load_data", load_data, e_ld);
        chk("load_we", 32'(load_we), 32'(ld && !e_err && !e_to));
      end
    end
    if (!got_done) chk("done_seen", 32'd0, 32'd1);
    op_valid = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
    op_funct3 = '0; op_addr = '0; op_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233);
    run_op(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
    run_op(1, 0, 3'b101, 32'h102, 32'h0, 2, 32'h80112233);
    run_op(1, 0, 3'b001, 32'h102, 32'h0, 0, 32'h80112233);
    run_op(0, 1, 3'b000, 32'h201, 32'hA5, 0, 32'h0);
    run_op(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0);
    run_op(0, 1, 3'b010, 32'h204, 32'h13579BDF, 3, 32'h0);
    run_op(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h11111111);
    run_op(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h11111111);
    run_op(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h11111111);
    run_op(0, 0, 3'b010, 32'h100, 32'h0, 0, 32'h11111111);
    run_op(0, 1, 3'b100, 32'h100, 32'h0, 0, 32'h0);
    run_op(1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0);
    run_op(1, 0, 3'b010, 32'h300, 32'h0, TMO, 32'hCAFEF00D);
    run_op(1, 0, 3'b010, 32'h300, 32'h0, 10, 32'hCAFEF00D);

    for (int i = 0; i < 300; i++) begin
      int unsigned kind;
      bit ld, st;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 19);
      ld = 1'($urandom); st = !ld;
      if (kind == 0) st = ld;
      f3 = (kind == 1) ? 3'($urandom) : (ld ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 2)));
      if (ld && f3 == 3'd3) f3 = 3'd5;
      a = $urandom;
      if (kind > 3) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      run_op(ld, st, f3, a, $urandom, $urandom_range(0, 5), $urandom);
    end

    @(negedge clk);
    op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_funct3 = 3'b010;
    op_addr = 32'h400; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", 32'(mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_we", 32'(load_we), 32'd0);
    chk("midrst_addr", mem_addr, 32'd0);
    chk("midrst_strb", 32'(mem_wstrb), 32'd0);
    op_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_req", 32'(mem_req), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage between the register file and writeback. Takes the effective address and store data (register-file RD2) and runs a ready/request transaction on the data-memory bus. For loads it aligns and sign- or zero-extends the returned word and produces the writeback data and write enable. It stalls the core until the transaction completes.

Parameters:
TIMEOUT, 255, max cycles in ACCESS waiting for mem_ready before aborting with err (1..255, 8-bit counter)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
op_valid  input  1  memory instruction present; core holds all op_* stable while stall=1
op_load  input  1  instruction is a load
op_store  input  1  instruction is a store
op_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
op_addr  input  32  effective byte address (ALU result)
op_wdata  input  32  store data (RD2)
mem_req  output  1  bus request, held until mem_ready
mem_we  output  1  1 = write
mem_addr  output  32  word address {op_addr[31:2],2'b00}
mem_wstrb  output  4  byte enables (stores), 0000 on loads
mem_wdata  output  32  lane-replicated store data
mem_ready  input  1  bus completes current request this cycle
mem_rdata  input  32  read data, valid when mem_ready=1 on a load
stall  output  1  core must not advance
done  output  1  one-cycle completion pulse
err  output  1  with done: misaligned, illegal op, or timeout
load_data  output  32  extended load result, feeds WD3
load_we  output  1  = done & op_load & ~err, feeds WE3

Behaviour:
- States IDLE, ACCESS, RESP. Async reset (reset=0) forces IDLE and clears all outputs: mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr, done, err, load_data, load_we and the timeout counter. Reset mid-ACCESS drops mem_req immediately. No partial writeback occurs.
- IDLE, op_valid=1: check the op.
  - err case: op_load=op_store, funct3 not in {000,001,010,100,101}, store funct3 in {100,101}, H/HU with addr[0]=1, or W with addr[1:0]!=00. Go to RESP with err=1 and no bus access.
  - Otherwise register addr, we, wstrb and wdata, clear the counter, and go to ACCESS.
- ACCESS: mem_req=1; addr, we, wstrb and wdata stay stable.
  - mem_ready=1: capture mem_rdata and go to RESP.
  - mem_ready=0: increment the counter. When counter==TIMEOUT, drop mem_req and go to RESP with err=1.
- RESP: done=1 for exactly one cycle, err valid, load_data valid (0 if err or store), load_we per its formula. Then go to IDLE.
- A new op is accepted only in IDLE, so back-to-back ops need at least one IDLE cycle between done and the next accept.
- stall = op_valid & ~done (combinational). The core advances on the done cycle.
- Latency: accept at cycle 0, mem_req at cycle 1; mem_ready at cycle 1 gives done at cycle 2. Each wait cycle adds 1. An err op gives done at cycle 1.
- Store strobes and data:
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata = op_wdata.
- Load extraction uses the captured word. Byte lane = addr[1:0], half lane = addr[1].
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- mem_rdata is ignored outside ACCESS with mem_ready=1. mem_ready in IDLE or RESP is ignored.
- Dropping op_valid mid-ACCESS is illegal. The transaction still completes.

Test Plan:
- LW at addr 0x100, mem_ready in the first ACCESS cycle, rdata 0xDEADBEEF -> mem_addr=0x100, done at cycle 2, load_data=0xDEADBEEF, load_we=1, err=0.
- LB at 0x103 with rdata 0x80112233 -> load_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x102 -> 0x00008011.
- SB at 0x201 with op_wdata 0x000000A5 -> mem_we=1, mem_addr=0x200, wstrb=0010, wdata=0xA5A5A5A5, load_we=0. SH at 0x202 -> wstrb=1100.
- LW at 0x102 -> no mem_req, done+err at cycle 1, load_we=0, load_data=0. Same for funct3=011 and for op_load=op_store=1.
- mem_ready held low with TIMEOUT=4 -> mem_req high for 4+1 cycles, then dropped, then done+err. stall is high throughout and falls when done pulses.
- Assert reset=0 during an ACCESS wait -> mem_req, stall-related state and outputs go to 0 immediately. After release with op_valid=0, the block stays IDLE.
